// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared region enum, default sizes and map helpers for mmio_memory
package mmio_pkg;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_SCREEN   = 2'd1,
        REG_KBD      = 2'd2,
        REG_UNMAPPED = 2'd3
    } region_t;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 15;
    localparam int DEF_RAM_DEPTH    = 16384;
    localparam int DEF_SCREEN_DEPTH = 8192;
    localparam int DEF_KB_DEPTH     = 4;

    // Screen sits directly above RAM.
    function automatic int unsigned screen_base(input int unsigned ram_depth);
        return ram_depth;
    endfunction

    // Keyboard word sits directly above the screen.
    function automatic int unsigned kbd_addr(input int unsigned ram_depth,
                                             input int unsigned screen_depth);
        return ram_depth + screen_depth;
    endfunction

endpackage

// File: rtl/mmio_kb_fifo.sv
// rtl/mmio_kb_fifo.sv - synchronous keyboard code FIFO with full-bypass push on pop
module mmio_kb_fifo
    import mmio_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int KB_DEPTH = DEF_KB_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           head,
    output logic [$clog2(KB_DEPTH):0]   count,
    output logic                        empty,
    output logic                        full
);

    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [KB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO only lands when the same cycle frees a slot;
    // a pop of an empty FIFO is simply dropped.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(KB_DEPTH));
        push_ok = push && (!full || pop);
        pop_ok  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Pointer, occupancy and storage update; pointers wrap naturally at KB_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/mmio_memory.sv
// rtl/mmio_memory.sv - RAM/screen/keyboard address space; MMIO_KB_FIFO_EN selects FIFO keyboard
module mmio_memory
    import mmio_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
    parameter int SCREEN_DEPTH = DEF_SCREEN_DEPTH,
    parameter int KB_DEPTH     = DEF_KB_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [ADDR_W-1:0]               address,
    input  logic [DATA_W-1:0]               in,
    output logic [DATA_W-1:0]               out,
    input  logic                            kb_valid,
    input  logic [DATA_W-1:0]               kb_data,
    input  logic [$clog2(SCREEN_DEPTH)-1:0] scan_addr,
    output logic [DATA_W-1:0]               scan_data,
    output logic [$clog2(KB_DEPTH):0]       kb_count,
    output logic                            kb_overflow,
    output logic                            addr_err
);

    localparam int          RAM_AW      = $clog2(RAM_DEPTH);
    localparam int          SCR_AW      = $clog2(SCREEN_DEPTH);
    localparam logic [31:0] SCREEN_BASE = 32'(screen_base(RAM_DEPTH));
    localparam logic [31:0] KBD_ADDR    = 32'(kbd_addr(RAM_DEPTH, SCREEN_DEPTH));

    logic [DATA_W-1:0] ram_mem    [RAM_DEPTH];
    logic [DATA_W-1:0] screen_mem [SCREEN_DEPTH];

    region_t           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic [DATA_W-1:0] kbd_word;

    // Address decode into region plus word index within that region.
    always_comb begin
        region  = REG_UNMAPPED;
        ram_idx = RAM_AW'(address);
        scr_idx = SCR_AW'(address - ADDR_W'(SCREEN_BASE));
        if (32'(address) < SCREEN_BASE) begin
            region = REG_RAM;
        end else if (32'(address) < KBD_ADDR) begin
            region = REG_SCREEN;
        end else if (32'(address) == KBD_ADDR) begin
            region = REG_KBD;
        end
    end

    // RAM writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (load && region == REG_RAM) begin
            ram_mem[ram_idx] <= in;
        end
    end

    // Screen writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (load && region == REG_SCREEN) begin
            screen_mem[scr_idx] <= in;
        end
    end

    // Scanner port: registered read that sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_data <= '0;
        end else begin
            scan_data <= screen_mem[scan_addr];
        end
    end

    // Any cycle spent addressing unmapped space is an access error.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (region == REG_UNMAPPED) begin
            addr_err <= 1'b1;
        end
    end

`ifdef MMIO_KB_FIFO_EN
    logic              kb_pop;
    logic [DATA_W-1:0] kb_head;
    logic              kb_empty;
    logic              kb_full;

    assign kb_pop = load && (region == REG_KBD);

    mmio_kb_fifo #(
        .DATA_W   (DATA_W),
        .KB_DEPTH (KB_DEPTH)
    ) u_kb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kb_valid),
        .push_data (kb_data),
        .pop       (kb_pop),
        .head      (kb_head),
        .count     (kb_count),
        .empty     (kb_empty),
        .full      (kb_full)
    );

    // Empty FIFO reads as zero, like an idle legacy keyboard.
    assign kbd_word = kb_empty ? '0 : kb_head;

    // A code is lost only when full and nothing is popped in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            kb_overflow <= 1'b0;
        end else if (kb_valid && kb_full && !kb_pop) begin
            kb_overflow <= 1'b1;
        end
    end
`else
    logic [DATA_W-1:0] kb_reg;
    logic              unused_kb_valid;

    assign unused_kb_valid = kb_valid;
    assign kb_count        = '0;
    assign kb_overflow     = 1'b0;
    assign kbd_word        = kb_reg;

    // Legacy keyboard: sample the current code every cycle.
    always_ff @(posedge clk) begin
        kb_reg <= kb_data;
    end
`endif

    // CPU read mux; unmapped space reads as zero.
    always_comb begin
        out = '0;
        case (region)
            REG_RAM:    out = ram_mem[ram_idx];
            REG_SCREEN: out = screen_mem[scr_idx];
            REG_KBD:    out = kbd_word;
            default:    out = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_memory.sv
// tb/tb_mmio_memory.sv - scoreboard bench for mmio_memory; MMIO_KB_FIFO_EN selects FIFO checks
module tb_mmio_memory;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int SCAN_W = 13;
    localparam int CNT_W  = 3;

    localparam int K_OUT  = 0;
    localparam int K_SCAN = 1;
    localparam int K_CNT  = 2;
    localparam int K_OVF  = 3;
    localparam int K_ERR  = 4;

    logic              clk;
    logic              reset;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] out;
    logic              kb_valid;
    logic [DATA_W-1:0] kb_data;
    logic [SCAN_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic [CNT_W-1:0]  kb_count;
    logic              kb_overflow;
    logic              addr_err;

    mmio_memory dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .address     (address),
        .in          (in),
        .out         (out),
        .kb_valid    (kb_valid),
        .kb_data     (kb_data),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .kb_count    (kb_count),
        .kb_overflow (kb_overflow),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic expect_val(input int kind, input string name, input logic [31:0] exp);
        chk_t c;
        c.kind = kind;
        c.name = name;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_OUT:   return 32'(out);
            K_SCAN:  return 32'(scan_data);
            K_CNT:   return 32'(kb_count);
            K_OVF:   return 32'(kb_overflow);
            default: return 32'(addr_err);
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle.
    chk_t        mon_c;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_c   = sb.pop_front();
            mon_act = observe(mon_c.kind);
            applied++;
            if (mon_act !== mon_c.exp) begin
                miscompares++;
                $display("FAIL %s: got %0d expected %0d", mon_c.name, mon_act, mon_c.exp);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        load    = 1'b1;
        address = a;
        in      = d;
        step();
        load    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        address   = '0;
        in        = '0;
        kb_valid  = 1'b0;
        kb_data   = '0;
        scan_addr = '0;
        step();
        step();
        expect_val(K_CNT,  "reset_kb_count", 0);
        expect_val(K_OVF,  "reset_kb_overflow", 0);
        expect_val(K_ERR,  "reset_addr_err", 0);
        expect_val(K_SCAN, "reset_scan_data", 0);
        reset = 1'b0;

        // RAM basics
        wr(15'h2000, 16'h1111);
        wr(15'h0001, 16'h0101);
        wr(15'h0000, 16'hFFFF);
        address = 15'h0000;
        expect_val(K_OUT, "ram0_write", 16'hFFFF);
        step();
        address = 15'h2000;
        expect_val(K_OUT, "ram2000_unaffected", 16'h1111);
        step();
        address = 15'h0000;
        in      = 16'd9999;
        expect_val(K_OUT, "ram0_load0", 16'hFFFF);
        step();

        // Screen and scanner read-before-write
        wr(15'h4001, 16'h0202);
        scan_addr = '0;
        wr(15'h4000, 16'd2222);
        address = 15'h4000;
        expect_val(K_OUT, "screen_cpu_read", 16'd2222);
        step();
        expect_val(K_SCAN, "scan_latency", 16'd2222);
        load = 1'b1;
        in   = 16'd7;
        step();
        load = 1'b0;
        expect_val(K_SCAN, "scan_read_before_write", 16'd2222);
        step();
        expect_val(K_SCAN, "scan_after_write", 16'd7);
        expect_val(K_OUT,  "screen_cpu_after_write", 16'd7);
        step();

        // Keyboard
        address = 15'h6000;
`ifdef MMIO_KB_FIFO_EN
        expect_val(K_OUT, "kb_empty_read", 0);
        kb_valid = 1'b1;
        kb_data  = 16'd65; step();
        kb_data  = 16'd66; step();
        kb_data  = 16'd67; step();
        kb_valid = 1'b0;
        expect_val(K_CNT, "kb_count_3", 3);
        expect_val(K_OUT, "kb_head_65", 65);
        wr(15'h6000, 16'd0);
        expect_val(K_OUT, "kb_head_66", 66);
        expect_val(K_CNT, "kb_count_2", 2);
        wr(15'h6000, 16'd0);
        wr(15'h6000, 16'd0);
        expect_val(K_OUT, "kb_drained_out", 0);
        expect_val(K_CNT, "kb_drained_count", 0);
        wr(15'h6000, 16'd0);
        expect_val(K_CNT, "kb_pop_empty_count", 0);
        expect_val(K_OVF, "kb_no_overflow_yet", 0);
        kb_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            kb_data = 16'(i);
            step();
        end
        kb_valid = 1'b0;
        expect_val(K_CNT, "kb_full_count", 4);
        expect_val(K_OVF, "kb_overflow_set", 1);
        expect_val(K_OUT, "kb_full_head", 1);
        kb_valid = 1'b1;
        kb_data  = 16'd9;
        wr(15'h6000, 16'd0);
        kb_valid = 1'b0;
        expect_val(K_CNT, "kb_full_pushpop_count", 4);
        expect_val(K_OUT, "kb_full_pushpop_head", 2);
        wr(15'h6000, 16'd0);
        expect_val(K_OUT, "kb_seq_3", 3);
        wr(15'h6000, 16'd0);
        expect_val(K_OUT, "kb_seq_4", 4);
        wr(15'h6000, 16'd0);
        expect_val(K_OUT, "kb_tail_9", 9);
        expect_val(K_CNT, "kb_tail_count", 1);
        step();
`else
        kb_data = 16'd81;
        step();
        expect_val(K_OUT, "kb_legacy_81", 81);
        expect_val(K_CNT, "kb_legacy_count", 0);
        kb_data = 16'd82;
        wr(15'h6000, 16'd5);
        expect_val(K_OUT, "kb_legacy_82", 82);
        expect_val(K_ERR, "kb_write_no_err", 0);
        expect_val(K_OVF, "kb_legacy_ovf", 0);
        step();
`endif

        // Unmapped access
        address = 15'h6001;
        expect_val(K_OUT, "unmapped_read_zero", 0);
        expect_val(K_ERR, "err_not_yet", 0);
        step();
        expect_val(K_ERR, "err_sticky_set", 1);
        wr(15'h6001, 16'hBEEF);
        address = 15'h0001;
        expect_val(K_OUT, "unmapped_wr_ram1", 16'h0101);
        expect_val(K_ERR, "err_still_set", 1);
        step();
        address = 15'h4001;
        expect_val(K_OUT, "unmapped_wr_scr1", 16'h0202);
        step();

        // Reset mid-stream, with a push in the reset cycle
        reset    = 1'b1;
        kb_valid = 1'b1;
        kb_data  = 16'd77;
        address  = 15'h0000;
        step();
        reset    = 1'b0;
        kb_valid = 1'b0;
        expect_val(K_ERR,  "post_reset_err", 0);
        expect_val(K_OVF,  "post_reset_ovf", 0);
        expect_val(K_CNT,  "post_reset_count", 0);
        expect_val(K_SCAN, "post_reset_scan", 0);
        expect_val(K_OUT,  "post_reset_ram0", 16'hFFFF);
        step();
`ifdef MMIO_KB_FIFO_EN
        address = 15'h6000;
        expect_val(K_OUT, "post_reset_kb_empty", 0);
        step();
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
